// File: rtl/microsequencer.sv
// microsequencer: address-sequencing stage of the multicycle MIPS control unit.
// Holds the microstate register, resolves the ROM's addrctl field (retire,
// dispatch 1, dispatch 2, increment), flags unsupported opcodes and counts
// retired instructions.
// Optional build macro: MICROSEQ_ADDI_EN adds addi (ADDIEX/ADDIWB) to dispatch 1.
module microsequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [5:0]             opcode,
  input  logic [1:0]             addrctl,
  output logic [3:0]             state,
  output logic                   illegal_op,
  output logic                   instr_done,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  // Microstate encodings (ROM index)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_JEX     = 4'd9;
`ifdef MICROSEQ_ADDI_EN
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
`endif

  // Opcodes recognised by the dispatch tables
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // addrctl field codes
  localparam logic [1:0] AC_RETIRE = 2'b00;
  localparam logic [1:0] AC_DISP1  = 2'b01;
  localparam logic [1:0] AC_DISP2  = 2'b10;
  localparam logic [1:0] AC_INCR   = 2'b11;

  // Dispatch lookup result: target state plus whether the opcode was known
  typedef struct packed {
    logic [3:0] nxt;
    logic       ok;
  } disp_t;

  // Dispatch 1 (from DECODE): selects the instruction class
  function automatic disp_t dispatch1(input logic [5:0] op);
    disp_t d;
    d.nxt = S_FETCH;
    d.ok  = 1'b1;
    case (op)
      OP_RTYPE: d.nxt = S_RTYPEEX;
      OP_LW:    d.nxt = S_MEMADR;
      OP_SW:    d.nxt = S_MEMADR;
      OP_BEQ:   d.nxt = S_BEQEX;
      OP_J:     d.nxt = S_JEX;
`ifdef MICROSEQ_ADDI_EN
      OP_ADDI:  d.nxt = S_ADDIEX;
`endif
      default:  d.ok  = 1'b0;
    endcase
    return d;
  endfunction

  // Dispatch 2 (from MEMADR): load vs store
  function automatic disp_t dispatch2(input logic [5:0] op);
    disp_t d;
    d.nxt = S_FETCH;
    d.ok  = 1'b1;
    case (op)
      OP_LW:   d.nxt = S_MEMRD;
      OP_SW:   d.nxt = S_MEMWR;
      default: d.ok  = 1'b0;
    endcase
    return d;
  endfunction

  logic [3:0] next_state;
  logic       bad_dispatch;
  logic       retire;
  logic       illegal_set;
  disp_t      d1;
  disp_t      d2;

  assign d1 = dispatch1(opcode);
  assign d2 = dispatch2(opcode);

  // State register: reset beats stall, stall freezes the microstate
  always_ff @(posedge clk) begin
    if (reset)       state <= S_FETCH;
    else if (!stall) state <= next_state;
  end

  // Next-state: decode addrctl for the current state; unused states 12-15
  // are not trapped and simply follow addrctl like any other state
  always_comb begin
    next_state   = state;
    bad_dispatch = 1'b0;
    case (addrctl)
      AC_RETIRE: next_state = S_FETCH;
      AC_DISP1: begin
        next_state   = d1.nxt;
        bad_dispatch = ~d1.ok;
      end
      AC_DISP2: begin
        next_state   = d2.nxt;
        bad_dispatch = ~d2.ok;
      end
      AC_INCR:   next_state = 4'(state + 4'd1);
      default:   next_state = state;
    endcase
  end

  // Outputs of the transition: retirement (addrctl=00 outside FETCH) and
  // illegal-opcode detection, both suppressed while stalled.  An illegal
  // dispatch lands in FETCH but is not a retirement.
  always_comb begin
    retire      = 1'b0;
    illegal_set = 1'b0;
    if (!stall) begin
      retire      = (addrctl == AC_RETIRE) && (state != S_FETCH);
      illegal_set = bad_dispatch;
    end
  end

  // Status registers: sticky illegal flag, one-cycle retire pulse, counter
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_op  <= 1'b0;
      instr_done  <= 1'b0;
      instr_count <= '0;
    end else begin
      instr_done <= retire;
      if (illegal_set) illegal_op  <= 1'b1;
      if (retire)      instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Address-sequencing stage of the multicycle MIPS control unit.
- Produces the 4-bit state index that feeds the microprogram ROM.
- Consumes the ROM's 2-bit addrctl field and the opcode held in the instruction register.
- Holds the state register and the dispatch tables, flags unsupported opcodes, and counts retired instructions.

Parameters:
COUNT_WIDTH, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  memory-not-ready; when 1, all registers hold
opcode  input  6  IR[31:26], valid from DECODE onward
addrctl  input  2  next-address control from microprogram ROM for current state
state  output  4  current microstate, drives ROM index
illegal_op  output  1  sticky flag: unsupported opcode dispatched
instr_done  output  1  one-cycle pulse when an instruction retires (return to FETCH)
instr_count  output  COUNT_WIDTH  number of retired instructions

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, JEX=9, ADDIEX=10, ADDIWB=11 (10 and 11 only with the optional feature).
- Reset (sampled on clk edge while reset=1): state=FETCH, illegal_op=0, instr_done=0, instr_count=0. Reset overrides stall.
- state is registered. addrctl is combinational from the ROM of the current state, so the next state is computed from the current state, addrctl and opcode, and loaded on the next edge. There is one cycle per microstate.
- addrctl decoding:
  - 00: next=FETCH (instruction retires).
  - 01: dispatch 1 on opcode.
  - 10: dispatch 2 on opcode.
  - 11: next=state+1, 4-bit wrap (15->0).
- Dispatch 1:
  - 000000 -> RTYPEEX
  - 100011 -> MEMADR
  - 101011 -> MEMADR
  - 000100 -> BEQEX
  - 000010 -> JEX
  - any other opcode -> FETCH, set illegal_op.
- Dispatch 2:
  - 100011 -> MEMRD
  - 101011 -> MEMWR
  - any other opcode -> FETCH, set illegal_op.
- illegal_op stays 1 until reset. The illegal dispatch does not count as a retirement.
- instr_done=1 for exactly the cycle after an edge on which addrctl=00 was applied with stall=0 and state!=FETCH.
  - instr_count increments on that same edge.
  - The counter wraps at 2^COUNT_WIDTH.
  - addrctl=00 while in FETCH is a no-op: no pulse, no count.
- stall=1:
  - state, illegal_op and instr_count hold.
  - instr_done is forced to 0.
  - addrctl and opcode are ignored that cycle.
  - Stall may assert in any state for any number of cycles.
- Simultaneous reset and stall: reset wins.
- Reset mid-instruction: the next cycle is FETCH with no retirement counted.
- Unknown/unused states (12–15): follow addrctl normally; no special trap.

Optional Feature:
- Macro: MICROSEQ_ADDI_EN.
- Defined:
  - Dispatch 1 maps 001000 (addi) -> ADDIEX.
  - ADDIEX uses addrctl=11 to reach ADDIWB; ADDIWB returns to FETCH and retires.
- Undefined:
  - 001000 is illegal in dispatch 1 -> FETCH, illegal_op=1.
  - States 10/11 are unreachable via dispatch.

Test Plan:
1. reset=1 for 2 cycles, then lw sequence (opcode=100011, addrctl 11,01,10,11,00 per state) -> state trace 0,1,2,3,4,0; instr_done pulses once; instr_count=1.
2. sw then beq then j (opcodes 101011, 000100, 000010) -> traces 0,1,2,5,0 / 0,1,8,0 / 0,1,9,0; instr_count=3; illegal_op=0.
3. opcode=111111 at DECODE with addrctl=01 -> next state 0, illegal_op=1 and stays 1 through a following legal R-type; instr_count does not increment for the illegal one.
4. stall=1 for 3 cycles while in MEMRD -> state stays 3, instr_done=0; after release, trace continues 4,0 and count +1.
5. reset asserted while in RTYPEEX with stall=1 -> next cycle state=0, illegal_op=0, instr_count=0.
6. opcode=001000 at DECODE -> with MICROSEQ_ADDI_EN: trace 0,1,10,11,0, count +1; without it: 0,1,0 with illegal_op=1.
